mem_wb_writeback: RTL
=====================

// Module: mem_wb_writeback
// PURPOSE
//  MEM/WB pipeline register plus write-back select. Sits directly upstream of the 32x32 register file.
//  Latches memory-stage results, extracts and extends load data, and picks ALU, load or link (PC+4).
//  Drives the regfile write port (WriteData/WriteRegister/RegWrite). Same outputs serve as forwarding source.
//  Keeps a retired-instruction counter.
// PARAMETERS
//  WIDTH     32  data path width
//  ADDR      5   register address width
//  LINK_REG  31  destination forced for link write-back (jal)
// PORTS
//  clock          in   1      rising-edge clock, single clock domain
//  reset          in   1      asynchronous, active-high reset
//  stall          in   1      hold stage contents
//  flush          in   1      bubble the stage (kill incoming capture)
//  in_valid       in   1      MEM stage holds a real instruction
//  in_RegWrite    in   1      instruction writes a register
//  in_WbSel       in   2      00 ALU, 01 MEM, 10 LINK, 11 reserved
//  in_LoadType    in   3      000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others=LW
//  in_ByteOffset  in   2      address[1:0] of the load
//  in_AluResult   in   WIDTH  ALU result
//  in_MemData     in   WIDTH  raw data-memory word
//  in_PcPlus4     in   WIDTH  link value
//  in_DestReg     in   ADDR   destination register
//  WriteData      out  WIDTH  to regfile WriteData
//  WriteRegister  out  ADDR   to regfile WriteRegister
//  RegWrite       out  1      to regfile RegWrite
//  wb_valid       out  1      stage holds a valid instruction
//  RetireCount    out  32     count of instructions leaving the stage
// BEHAVIOUR
//  - Reset (async, active-high): all stage registers, wb_valid, RetireCount = 0.
//    Hence RegWrite=0, WriteData=0, WriteRegister=0. Applies mid-operation; any pending write is lost.
//  - Posedge, priority flush > stall > load:
//    - flush: wb_valid<=0, other fields don't-care.
//    - stall: hold everything.
//    - load: capture all in_*, wb_valid<=in_valid.
//  - Latency: 1 cycle. Inputs captured at edge N drive the regfile during cycle N. Regfile commits at edge N+1.
//  - Outputs are combinational from stage registers only (no in_* to output path).
//  - RegWrite = wb_valid & r_RegWrite & (r_WbSel != 11) & (WriteRegister != 0).
//    Writes to $0 are never issued.
//  - WriteRegister = (r_WbSel==LINK) ? LINK_REG : r_DestReg.
//  - WriteData:
//    - ALU/reserved: r_AluResult
//    - LINK: r_PcPlus4
//    - MEM: load-extended r_MemData
//  - Load extend, little-endian, byte k = MemData[8k+7:8k]:
//    - LB/LBU select byte ByteOffset; sign-/zero-extend.
//    - LH/LHU select half ByteOffset[1]; ByteOffset[0] ignored (alignment checked upstream); sign-/zero-extend.
//  - Stall with valid content: RegWrite stays asserted, same value rewritten each edge (idempotent).
//  - Retire: RetireCount++ at an edge where wb_valid & (!stall | flush).
//    Stall alone does not count; flush still lets current content leave. Wraps FFFFFFFF->0.
//  - Simultaneous flush+stall behaves as flush.
// STRUCTURE
//  - wb_defs.vh (shared include): WbSel codes, LoadType codes, LINK_REG; also used by decode/control.
//  - Sub-module load_extend (combinational: MemData, LoadType, ByteOffset -> WIDTH result).
//    Instantiated once on the registered side.
// TESTING
//  1. Reset asserted mid-cycle with valid stage -> RegWrite, WriteData, RetireCount = 0 immediately (async).
//  2. ALU write: AluResult=0x1234_5678, Dest=5, WbSel=00 -> next cycle RegWrite=1, WriteRegister=5,
//     WriteData=0x12345678. Regfile read of r5 = 0x12345678 after following edge.
//  3. MemData=0x80FF_7F01:
//     - LB off=3 -> 0xFFFFFF80
//     - LBU off=3 -> 0x00000080
//     - LH off=2 -> 0xFFFF80FF
//     - LHU off=0 -> 0x00007F01
//  4. jal: WbSel=10, PcPlus4=0x0040_0008, Dest=0 -> WriteRegister=31, WriteData=0x00400008, RegWrite=1.
//     Dest=0 with WbSel=00 -> RegWrite=0.
//  5. Stall 3 cycles with valid content -> outputs frozen, RetireCount unchanged.
//     Release -> +1. flush+stall -> wb_valid=0 next cycle, count +1.
//  6. Preload RetireCount path to 0xFFFFFFFF (force), retire one -> 0x00000000.

Source files
------------

// File: rtl/mem_wb_writeback_pkg.sv
// Shared write-back codes for the MEM/WB stage: select codes, load types and the link register.
// Decode/control imports the same definitions so both ends agree on the encodings.
package mem_wb_writeback_pkg;

  localparam int             WB_WIDTH    = 32;
  localparam int             WB_ADDR     = 5;
  localparam logic [4:0]     WB_LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LB  = 3'b001,
    LD_LBU = 3'b010,
    LD_LH  = 3'b011,
    LD_LHU = 3'b100
  } load_type_e;

  // A reserved select never produces a register write.
  function automatic logic wb_sel_writes(input logic [1:0] sel);
    return (sel != WB_RSVD);
  endfunction

endpackage

// File: rtl/mem_wb_writeback_if.sv
// MEM-to-WB bundle: stage controls, memory-stage results in, regfile write port and status out.
// The master side is the MEM stage; the slave side is the MEM/WB register.
interface mem_wb_writeback_if #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5
);
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic             in_RegWrite;
  logic [1:0]       in_WbSel;
  logic [2:0]       in_LoadType;
  logic [1:0]       in_ByteOffset;
  logic [WIDTH-1:0] in_AluResult;
  logic [WIDTH-1:0] in_MemData;
  logic [WIDTH-1:0] in_PcPlus4;
  logic [ADDR-1:0]  in_DestReg;

  logic [WIDTH-1:0] WriteData;
  logic [ADDR-1:0]  WriteRegister;
  logic             RegWrite;
  logic             wb_valid;
  logic [31:0]      RetireCount;

  modport master (
    output stall, flush, in_valid, in_RegWrite, in_WbSel, in_LoadType, in_ByteOffset,
           in_AluResult, in_MemData, in_PcPlus4, in_DestReg,
    input  WriteData, WriteRegister, RegWrite, wb_valid, RetireCount
  );

  modport slave (
    input  stall, flush, in_valid, in_RegWrite, in_WbSel, in_LoadType, in_ByteOffset,
           in_AluResult, in_MemData, in_PcPlus4, in_DestReg,
    output WriteData, WriteRegister, RegWrite, wb_valid, RetireCount
  );
endinterface

// File: rtl/mem_wb_writeback_load_extend.sv
// Little-endian load extraction: picks a byte/half from the memory word and sign- or zero-extends it.
// Purely combinational; fed from the registered side of the MEM/WB stage.
module mem_wb_writeback_load_extend
  import mem_wb_writeback_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic [WIDTH-1:0] i_MemData,
  input  logic [2:0]       i_LoadType,
  input  logic [1:0]       i_ByteOffset,
  output logic [WIDTH-1:0] o_Result
);

  logic [7:0]  w_bytes  [4];
  logic [15:0] w_halves [2];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign w_bytes[gi] = i_MemData[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_halves
      assign w_halves[gi] = i_MemData[16*gi +: 16];
    end
  endgenerate

  // Halfword alignment is guaranteed upstream, so offset bit 0 is ignored for halves.
  assign w_byte = w_bytes[i_ByteOffset];
  assign w_half = w_halves[i_ByteOffset[1]];

  always_comb begin
    o_Result = i_MemData;
    case (i_LoadType)
      LD_LB:   o_Result = {{(WIDTH-8){w_byte[7]}}, w_byte};
      LD_LBU:  o_Result = {{(WIDTH-8){1'b0}}, w_byte};
      LD_LH:   o_Result = {{(WIDTH-16){w_half[15]}}, w_half};
      LD_LHU:  o_Result = {{(WIDTH-16){1'b0}}, w_half};
      default: o_Result = i_MemData;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with write-back select driving the register-file write port.
// Outputs depend only on stage registers, so they double as a clean forwarding source.
module mem_wb_writeback
  import mem_wb_writeback_pkg::*;
#(
  parameter int         WIDTH    = WB_WIDTH,
  parameter int         ADDR     = WB_ADDR,
  parameter logic [4:0] LINK_REG = WB_LINK_REG
) (
  input logic               clock,
  input logic               reset,
  mem_wb_writeback_if.slave bus
);

  logic             r_valid;
  logic             r_RegWrite;
  logic [1:0]       r_WbSel;
  logic [2:0]       r_LoadType;
  logic [1:0]       r_ByteOffset;
  logic [WIDTH-1:0] r_AluResult;
  logic [WIDTH-1:0] r_MemData;
  logic [WIDTH-1:0] r_PcPlus4;
  logic [ADDR-1:0]  r_DestReg;
  logic [31:0]      r_RetireCount;

  logic [WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0] w_WriteData;
  logic [ADDR-1:0]  w_WriteRegister;
  logic             w_retire;

  // Current content leaves the stage on any non-stalled edge, and a flush also lets it go.
  assign w_retire = r_valid & (~bus.stall | bus.flush);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_RegWrite    <= 1'b0;
      r_WbSel       <= 2'b00;
      r_LoadType    <= 3'b000;
      r_ByteOffset  <= 2'b00;
      r_AluResult   <= '0;
      r_MemData     <= '0;
      r_PcPlus4     <= '0;
      r_DestReg     <= '0;
      r_RetireCount <= 32'd0;
    end else begin
      if (w_retire) begin
        r_RetireCount <= r_RetireCount + 32'd1;
      end
      if (bus.flush) begin
        r_valid <= 1'b0;
      end else if (!bus.stall) begin
        r_valid      <= bus.in_valid;
        r_RegWrite   <= bus.in_RegWrite;
        r_WbSel      <= bus.in_WbSel;
        r_LoadType   <= bus.in_LoadType;
        r_ByteOffset <= bus.in_ByteOffset;
        r_AluResult  <= bus.in_AluResult;
        r_MemData    <= bus.in_MemData;
        r_PcPlus4    <= bus.in_PcPlus4;
        r_DestReg    <= bus.in_DestReg;
      end
    end
  end

  mem_wb_writeback_load_extend #(
    .WIDTH (WIDTH)
  ) u_load_extend (
    .i_MemData    (r_MemData),
    .i_LoadType   (r_LoadType),
    .i_ByteOffset (r_ByteOffset),
    .o_Result     (w_load_data)
  );

  assign w_WriteRegister = (r_WbSel == WB_LINK) ? ADDR'(LINK_REG) : r_DestReg;

  always_comb begin
    w_WriteData = r_AluResult;
    case (r_WbSel)
      WB_MEM:  w_WriteData = w_load_data;
      WB_LINK: w_WriteData = r_PcPlus4;
      default: w_WriteData = r_AluResult;
    endcase
  end

  assign bus.WriteData     = w_WriteData;
  assign bus.WriteRegister = w_WriteRegister;
  // Register 0 is hardwired, so a write to it is suppressed here rather than in the regfile.
  assign bus.RegWrite      = r_valid & r_RegWrite & wb_sel_writes(r_WbSel) & (w_WriteRegister != '0);
  assign bus.wb_valid      = r_valid;
  assign bus.RetireCount   = r_RetireCount;

endmodule
